dcache_repl_policy: RTL and testbench
=====================================

Name: dcache_repl_policy

Overview:
Parametrised victim-selection unit for the set-associative dCache. It holds per-set replacement state for a runtime-fixed policy: round-robin, tree pseudo-LRU or LFSR pseudo-random. It always prefers an invalid way, returns a registered victim one cycle after a request, and updates state from hit-access and line-fill events. It sits beside the dCache controller FSM and replaces the single global round-robin counter.

Parameters:
NUM_WAYS, 4, associativity; power of two, 2..8
NUM_SETS, 64, sets; power of two, >=2
POLICY, 1, 0=round-robin, 1=tree-PLRU, 2=LFSR random
WAY_W, $clog2(NUM_WAYS), way index width (derived)
SET_W, $clog2(NUM_SETS), set index width (derived)

Ports:
clk  in  1  clock
reset  in  1  reset
acc_valid  in  1  cache hit on acc_set/acc_way this cycle
acc_set  in  SET_W  set of hit
acc_way  in  WAY_W  way of hit
vic_req  in  1  miss; request a victim for vic_set
vic_set  in  SET_W  set needing a victim
line_valid  in  NUM_WAYS  valid bits of vic_set, sampled with vic_req
vic_valid  out  1  victim result valid, one-cycle pulse
vic_way  out  WAY_W  selected victim way
fill_valid  in  1  refill committed into fill_set/fill_way
fill_set  in  SET_W  set of fill
fill_way  in  WAY_W  way of fill

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset, all per-set RR pointers and PLRU bits are 0, the LFSR is 16'hACE1, vic_valid is 0 and vic_way is 0. Reset overrides every other input in that cycle.
- Victim latency: vic_req in cycle N gives vic_valid=1 with vic_way in cycle N+1. vic_valid is 0 in every cycle without a preceding request. vic_way holds its last value when vic_valid=0. Back-to-back requests give back-to-back results.
- Selection priority: if any line_valid bit is 0, the victim is the lowest-index invalid way. Otherwise the victim comes from the policy.
- Victim selection does not modify state. Only acc_valid and fill_valid update state.
- RR: per-set WAY_W pointer. The victim is ptr[vic_set]. On fill, ptr[fill_set] <= fill_way+1 modulo NUM_WAYS, wrapping from NUM_WAYS-1 to 0. Access does not affect RR.
- PLRU: NUM_WAYS-1 tree bits per set, heap-ordered, with node 0 as root. A bit value of 0 means the victim lies in the left subtree. To pick a victim, walk from the root following the bits. A touch (access or fill) sets every node on the path to the touched way so that it points away from that way.
- LFSR: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advancing every cycle out of reset. The victim is lfsr[WAY_W-1:0] as sampled in the request cycle. State is shared across sets. Access and fill are ignored.
- Simultaneous acc_valid and fill_valid:
  - Different sets: both updates apply.
  - Same set: only the fill update applies.
- vic_req in the same cycle as an update to the same set: the victim uses the pre-update state.
- Out-of-range way inputs cannot occur, because WAY_W is exact for a power-of-two NUM_WAYS. The parameter check is an elaboration-time assertion on NUM_WAYS, NUM_SETS and POLICY.
- State storage is a flop array, to allow single-cycle synchronous clear. No SRAM is used.

Decomposition:
- Package dcache_repl_pkg holds:
  - enum repl_policy_e {REPL_RR, REPL_PLRU, REPL_LFSR}
  - LFSR_SEED = 16'hACE1
  - LFSR_TAPS = 16'hB400
  - functions plru_victim(bits) and plru_touch(bits, way), parametrised by NUM_WAYS
- One sub-module, dcache_repl_lfsr: a free-running 16-bit LFSR with synchronous reset and a seed parameter.
- RR and PLRU state are generated inside the top module under a generate on POLICY.

Test Plan:
1. Invalid-first: POLICY=1, NUM_WAYS=4, vic_req set 5 with line_valid=4'b1011 -> next cycle vic_valid=1, vic_way=2. With line_valid=4'b0000 -> vic_way=0.
2. PLRU order: after reset, all valid; fills to set 3 on ways 0,1,2,3 in sequence, then vic_req set 3 -> vic_way=0. Then acc way 0 and vic_req -> vic_way=2.
3. RR wrap: POLICY=0, fill set 7 way 3 -> vic_req set 7 gives vic_way=0. Fill way 0 -> gives 1. Set 8 is untouched -> gives 0.
4. Collision: POLICY=1, same cycle acc set 2 way 0, fill set 2 way 3, and vic_req set 2 all valid -> vic_way reflects reset state (0). The following request -> vic_way=0, because only the fill was applied.
5. LFSR: POLICY=2, vic_req in the first cycle after reset -> vic_way=16'hACE1[1:0]=1. The sequence matches the reference model for 1000 cycles.
6. Reset mid-operation: vic_req asserted together with reset -> no vic_valid next cycle, and all sets return vic_way=0 under RR and PLRU.

Source files
------------

// File: rtl/dcache_repl_pkg.sv
// Shared types, constants and tree-PLRU helpers for the dCache victim-selection unit.
// The helpers work on a tree of up to 8 ways. num_ways selects how many levels are used.
package dcache_repl_pkg;

  typedef enum logic [1:0] {
    REPL_RR   = 2'd0,
    REPL_PLRU = 2'd1,
    REPL_LFSR = 2'd2
  } repl_policy_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned plru_levels(input int unsigned num_ways);
    int unsigned lv;
    lv = 0;
    for (int unsigned l = 0; l < 3; l++) begin
      if ((32'd1 << l) < num_ways) lv++;
    end
    return lv;
  endfunction

  // Heap-ordered tree: children of node n are 2n+1 (left) and 2n+2 (right).
  function automatic logic [2:0] plru_victim(input logic [6:0] bits,
                                             input int unsigned num_ways);
    logic [2:0]  way;
    int unsigned node;
    int unsigned lv;
    way  = '0;
    node = 0;
    lv   = plru_levels(num_ways);
    for (int unsigned l = 0; l < 3; l++) begin
      if (l < lv) begin
        way  = {way[1:0], bits[3'(node)]};
        node = bits[3'(node)] ? 2 * node + 2 : 2 * node + 1;
      end
    end
    return way;
  endfunction

  function automatic logic [6:0] plru_touch(input logic [6:0] bits,
                                            input logic [2:0] way,
                                            input int unsigned num_ways);
    logic [6:0]  res;
    int unsigned node;
    int unsigned lv;
    logic        dir;
    res  = bits;
    node = 0;
    lv   = plru_levels(num_ways);
    for (int unsigned l = 0; l < 3; l++) begin
      if (l < lv) begin
        dir            = way[2'(lv - 1 - l)];
        res[3'(node)]  = ~dir;
        node           = dir ? 2 * node + 2 : 2 * node + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_repl_lfsr.sv
// Free-running 16-bit Galois LFSR used by the random replacement policy.
module dcache_repl_lfsr
  import dcache_repl_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/dcache_repl_policy.sv
// Per-set victim selection for the set-associative dCache (round-robin, tree-PLRU or LFSR).
// Invalid ways win over the policy; the victim is registered one cycle after vic_req.
module dcache_repl_policy
  import dcache_repl_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  parameter int POLICY   = 1,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                acc_valid,
  input  logic [SET_W-1:0]    acc_set,
  input  logic [WAY_W-1:0]    acc_way,
  input  logic                vic_req,
  input  logic [SET_W-1:0]    vic_set,
  input  logic [NUM_WAYS-1:0] line_valid,
  output logic                vic_valid,
  output logic [WAY_W-1:0]    vic_way,
  input  logic                fill_valid,
  input  logic [SET_W-1:0]    fill_set,
  input  logic [WAY_W-1:0]    fill_way
);

  localparam repl_policy_e POL = repl_policy_e'(POLICY);

  if (NUM_WAYS < 2 || NUM_WAYS > 8 || (NUM_WAYS & (NUM_WAYS - 1)) != 0 ||
      NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0 ||
      POLICY < 0 || POLICY > 2) begin : g_bad_params
    $error("dcache_repl_policy: unsupported NUM_WAYS/NUM_SETS/POLICY");
  end

  logic                vic_valid_q;
  logic [WAY_W-1:0]    vic_way_q;
  logic [WAY_W-1:0]    vic_way_d;
  logic [WAY_W-1:0]    pol_way;
  logic                inv_found;

  always_comb begin
    vic_way_d = pol_way;
    inv_found = 1'b0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (!line_valid[i] && !inv_found) begin
        vic_way_d = WAY_W'(i);
        inv_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vic_valid_q <= 1'b0;
      vic_way_q   <= '0;
    end else begin
      vic_valid_q <= vic_req;
      if (vic_req) vic_way_q <= vic_way_d;
    end
  end

  assign vic_valid = vic_valid_q;
  assign vic_way   = vic_way_q;

  if (POL == REPL_RR) begin : g_rr
    logic [WAY_W-1:0] ptr_q [NUM_SETS];
    logic             unused_acc;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
      end else if (fill_valid) begin
        ptr_q[fill_set] <= fill_way + WAY_W'(1);
      end
    end

    assign pol_way    = ptr_q[vic_set];
    assign unused_acc = ^{acc_valid, acc_set, acc_way};

  end else if (POL == REPL_PLRU) begin : g_plru
    logic [NUM_WAYS-2:0] plru_q [NUM_SETS];

    // A same-set access is dropped when a fill lands in that set this cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
      end else begin
        if (fill_valid)
          plru_q[fill_set] <= (NUM_WAYS-1)'(plru_touch(7'(plru_q[fill_set]), 3'(fill_way), NUM_WAYS));
        if (acc_valid && !(fill_valid && acc_set == fill_set))
          plru_q[acc_set] <= (NUM_WAYS-1)'(plru_touch(7'(plru_q[acc_set]), 3'(acc_way), NUM_WAYS));
      end
    end

    assign pol_way = WAY_W'(plru_victim(7'(plru_q[vic_set]), NUM_WAYS));

  end else begin : g_lfsr
    logic [15:0] lfsr;
    logic        unused_in;

    dcache_repl_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .lfsr_o (lfsr)
    );

    assign pol_way   = lfsr[WAY_W-1:0];
    assign unused_in = ^{lfsr[15:WAY_W], vic_set, acc_valid, acc_set, acc_way,
                         fill_valid, fill_set, fill_way};
  end

endmodule

// File: tb/tb_dcache_repl_policy.sv
// Directed bench for dcache_repl_policy: RR, PLRU and LFSR instances share one stimulus stream.
module tb_dcache_repl_policy;

  logic       clk = 1'b0;
  logic       reset;
  logic       acc_valid;
  logic [5:0] acc_set;
  logic [1:0] acc_way;
  logic       vic_req;
  logic [5:0] vic_set;
  logic [3:0] line_valid;
  logic       fill_valid;
  logic [5:0] fill_set;
  logic [1:0] fill_way;

  logic       vv_rr, vv_pl, vv_lf;
  logic [1:0] vw_rr, vw_pl, vw_lf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_repl_policy #(.NUM_WAYS(4), .NUM_SETS(64), .POLICY(0)) u_rr (
    .clk(clk), .reset(reset), .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way),
    .vic_req(vic_req), .vic_set(vic_set), .line_valid(line_valid),
    .vic_valid(vv_rr), .vic_way(vw_rr),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way));

  dcache_repl_policy #(.NUM_WAYS(4), .NUM_SETS(64), .POLICY(1)) u_plru (
    .clk(clk), .reset(reset), .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way),
    .vic_req(vic_req), .vic_set(vic_set), .line_valid(line_valid),
    .vic_valid(vv_pl), .vic_way(vw_pl),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way));

  dcache_repl_policy #(.NUM_WAYS(4), .NUM_SETS(64), .POLICY(2)) u_lfsr (
    .clk(clk), .reset(reset), .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way),
    .vic_req(vic_req), .vic_set(vic_set), .line_valid(line_valid),
    .vic_valid(vv_lf), .vic_way(vw_lf),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way));

  typedef struct {
    logic       rst;
    logic       av;
    logic [5:0] as;
    logic [1:0] aw;
    logic       fv;
    logic [5:0] fs;
    logic [1:0] fw;
    logic       vr;
    logic [5:0] vs;
    logic [3:0] lv;
    logic       lf;
    logic [1:0] e_rr;
    logic [1:0] e_pl;
    logic [1:0] e_lf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic av, input int as, input int aw,
                              input logic fv, input int fs, input int fw,
                              input logic vr, input int vs, input logic [3:0] lv,
                              input logic lf, input int e_rr, input int e_pl, input int e_lf);
    vec_t v;
    v.rst = rst; v.av = av; v.as = 6'(as); v.aw = 2'(aw);
    v.fv = fv; v.fs = 6'(fs); v.fw = 2'(fw);
    v.vr = vr; v.vs = 6'(vs); v.lv = lv; v.lf = lf;
    v.e_rr = 2'(e_rr); v.e_pl = 2'(e_pl); v.e_lf = 2'(e_lf);
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset      = v.rst;
    acc_valid  = v.av;  acc_set  = v.as; acc_way  = v.aw;
    fill_valid = v.fv;  fill_set = v.fs; fill_way = v.fw;
    vic_req    = v.vr;  vic_set  = v.vs; line_valid = v.lv;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        ev;
    logic [15:0] m;
    vec_t        idle;

    //            rst av as aw  fv fs fw  vr vs lv       lf rr pl lf
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 4'b1011, 1, 2, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 4'b0000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 4'b0111, 1, 3, 3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,    1, 3, 3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 4'hF,    0, 3, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0, 0, 4'hF,    0, 3, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 2, 0, 0, 4'hF,    0, 3, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 3, 0, 0, 4'hF,    0, 3, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 4'hF,    0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 0, 0, 1, 3, 4'hF,    0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 4'hF,    0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 3, 0, 0, 4'hF,    0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 0, 0, 0, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 4'hF,    0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 2, 1, 7, 4'hF,    0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 4'hF,    0, 3, 1, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 2, 3, 1, 2, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 1,10, 1, 1,11, 0, 0, 0, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,10, 4'hF,    0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,11, 4'hF,    0, 1, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,11, 4'hF,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 4'hF,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,11, 4'hF,    0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      ev = vecs[i].vr & ~vecs[i].rst;
      check($sformatf("row%0d rr valid", i), 8'(vv_rr), 8'(ev));
      check($sformatf("row%0d rr way", i), 8'(vw_rr), 8'(vecs[i].e_rr));
      check($sformatf("row%0d plru valid", i), 8'(vv_pl), 8'(ev));
      check($sformatf("row%0d plru way", i), 8'(vw_pl), 8'(vecs[i].e_pl));
      if (vecs[i].lf) begin
        check($sformatf("row%0d lfsr valid", i), 8'(vv_lf), 8'(ev));
        check($sformatf("row%0d lfsr way", i), 8'(vw_lf), 8'(vecs[i].e_lf));
      end
    end

    // LFSR sequence: request every cycle straight out of reset.
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    drive(idle);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    vic_req = 1'b1;
    m = 16'hACE1;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) check("lfsr first victim", 8'(vw_lf), 8'd1);
      check($sformatf("lfsr valid c%0d", n), 8'(vv_lf), 8'd1);
      check($sformatf("lfsr way c%0d", n), 8'(vw_lf), 8'(m[1:0]));
      m = lfsr_step(m);
    end
    vic_req = 1'b0;
    @(posedge clk);
    #1;
    check("lfsr valid drop", 8'(vv_lf), 8'd0);
    check("rr valid drop", 8'(vv_rr), 8'd0);
    check("plru valid drop", 8'(vv_pl), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
